uart_rx: RTL and testbench

Serial receiver for the UART link: recovers 8-bit bytes from an asynchronous idle-high serial line (start bit, 8 data bits LSB first, optional even parity, one stop bit). It runs entirely on the system clock, using a bit-period counter in place of a separate UART clock. It is the receiving end paired with the existing UART transmit path, and feeds received bytes to the system logic through a one-cycle valid strobe.

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: system-clock oversampling UART receiver, 8 data bits LSB first, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and the parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_sis,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT >> 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [1:0]    sync_ff;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          stop_pend;
  logic          stop_bit;
`ifdef UART_RX_PARITY_EN
  logic          par_flag;
`endif

  assign rx_s = sync_ff[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      sync_ff    <= 2'b11;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      stop_pend  <= 1'b0;
      stop_bit   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flag   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync_ff    <= {sync_ff[0], rx};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_BIT) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_BIT) begin
            cnt      <= '0;
            par_flag <= (rx_s != ^shift);
            state    <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // The stop sample is held for one cycle so the result pulses land one edge after it.
          if (stop_pend) begin
            stop_pend <= 1'b0;
            if (!stop_bit) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_flag) begin
              parity_err <= 1'b1;
              state      <= IDLE;
            end
`endif
            else begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= IDLE;
            end
          end else if (cnt == CNT_BIT) begin
            cnt       <= '0;
            stop_pend <= 1'b1;
            stop_bit  <= rx_s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks pulses, data and busy against a frame-level model.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C >> 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Start bit driven just after edge P0: two synchronizer edges, then E = P0+3.
  localparam int OFS = 3 + HALF + 9 * C + (PAR_EN ? C : 0) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       perr;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_sis   (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr),
`endif
    .busy      (busy)
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
    logic [7:0] data;
    logic       busy;
  } pulse_t;
  pulse_t seen_q[$];

  // Pulse vector is {parity_err, frame_err, data_valid}.
  always @(negedge clk) begin
    if (!rst && ({perr, frame_err, data_valid} != 3'b000))
      seen_q.push_back('{cyc, {perr, frame_err, data_valid}, data_out, busy});
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] model_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [2:0] expect_vec(input logic [7:0] b, input logic pbit, input logic sbit);
    if (!sbit) return 3'b010;
    if (PAR_EN && (pbit != ^b)) return 3'b100;
    return 3'b001;
  endfunction

  // Caller must be positioned just after a rising edge; returns at the same phase.
  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic sbit, output int t0);
    t0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle_cycles(C);
      rx = b[i];
    end
    if (PAR_EN) begin
      idle_cycles(C);
      rx = pbit;
    end
    idle_cycles(C);
    rx = sbit;
    idle_cycles(C);
  endtask

  task automatic check_frame(input int t0, input logic [2:0] exp_vec, input logic [7:0] exp_byte);
    chk("pulse_count", seen_q.size(), (exp_vec != 3'b000) ? 1 : 0);
    if (seen_q.size() > 0) begin
      chk("pulse_cycle", seen_q[0].cyc - t0, OFS);
      chk("pulse_kind", seen_q[0].vec, exp_vec);
      if (exp_vec == 3'b001) model_data = exp_byte;
      chk("data_out", seen_q[0].data, model_data);
      chk("busy_at_pulse", seen_q[0].busy, (exp_vec == 3'b010) ? 1 : 0);
    end
    seen_q.delete();
  endtask

  // Line held low after a bad stop bit: busy must hold until rx_s is high again.
  task automatic recover(input int extra);
    int t;
    idle_cycles(extra);
    chk("busy_in_break", busy, 1);
    rx = 1'b1;
    t  = cyc;
    at_neg(t + 2);
    chk("busy_before_idle", busy, 1);
    at_neg(t + 3);
    chk("busy_after_idle", busy, 0);
    @(posedge clk); #1;
    idle_cycles(C);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_parity_err"}, perr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    logic [2:0] exp_vec;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vec_t       tbl[$];
    int         t0;
    logic [7:0] b;
    logic       pb, sb;

    tbl.push_back('{8'h5B, 1'b1, 1'b1, 3'b001});
    tbl.push_back('{8'h42, 1'b0, 1'b1, 3'b001});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'b001});
    tbl.push_back('{8'hFF, 1'b0, 1'b1, 3'b001});
    tbl.push_back('{8'hA5, 1'b0, 1'b1, 3'b001});
    tbl.push_back('{8'h42, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{8'h5B, 1'b1, 1'b1, 3'b001});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h5B, 1'b0, 1'b1, 3'b100});
    tbl.push_back('{8'h01, 1'b0, 1'b1, 3'b100});
    tbl.push_back('{8'h80, 1'b1, 1'b1, 3'b001});
`endif
    tbl.push_back('{8'h3C, 1'b0, 1'b1, 3'b001});

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(C);
    chk("idle_busy", busy, 0);

    // Table rows with a good stop bit run back-to-back.
    for (int i = 0; i < tbl.size(); i++) begin
      send_frame(tbl[i].data, tbl[i].pbit, tbl[i].sbit, t0);
      check_frame(t0, tbl[i].exp_vec, tbl[i].data);
      if (!tbl[i].sbit) recover(40);
    end

    // Glitch: 4 low cycles only.
    idle_cycles(C);
    t0 = cyc;
    rx = 1'b0;
    idle_cycles(4);
    rx = 1'b1;
    at_neg(t0 + 6);
    chk("glitch_busy_high", busy, 1);
    at_neg(t0 + 12);
    chk("glitch_busy_low", busy, 0);
    @(posedge clk); #1;
    idle_cycles(2 * C);
    chk("glitch_no_pulse", seen_q.size(), 0);
    chk("glitch_data_out", data_out, model_data);
    seen_q.delete();

    // Reset in the middle of data bit 3 of 0x5B.
    b  = 8'h5B;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_cycles(C);
      rx = b[i];
    end
    repeat (C / 2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    model_data = 8'h00;
    chk("midreset_no_pulse", seen_q.size(), 0);
    seen_q.delete();
    @(posedge clk); #1;
    idle_cycles(C);
    send_frame(8'h42, 1'b0, 1'b1, t0);
    check_frame(t0, 3'b001, 8'h42);

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      pb = (^b) ^ ($urandom_range(0, 3) == 0);
      send_frame(b, pb, sb, t0);
      check_frame(t0, expect_vec(b, pb, sb), b);
      if (!sb) recover($urandom_range(0, 30));
      else if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 20));
    end

    idle_cycles(C);
    chk("final_no_stray_pulse", seen_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
